// File: rtl/fb_write_scheduler.sv
// ----------------------------------------------------------------------------
// fb_write_scheduler
//
// Purpose:
//   Funnels two write sources into a single frame-buffer write port:
//     * single-pixel writes (px_*), and
//     * a rectangle-fill engine (fill_*) that walks an inclusive rectangle
//       row by row, one pixel per granted cycle.
//   One write is issued per cycle. When both sources compete, grants
//   alternate, with the pixel source served first. The frame-buffer port
//   (addr_in / data_in / regwrite) is registered. A write granted in cycle N
//   appears on the port in cycle N+1 for exactly one cycle.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   px_valid/x/y/data     pixel write request
//   px_ready              pixel granted this cycle (combinational)
//   px_drop               one-cycle pulse. The granted pixel was off-frame and discarded.
//   fill_start            start a fill (only honoured while idle)
//   fill_x0/x1/y0/y1      inclusive rectangle corners, sampled at start
//   fill_color            fill colour, sampled at start
//   fill_busy             fill engine in FILL or DONE
//   fill_done             one-cycle pulse after the fill completes
//   addr_in, data_in      frame-buffer write address / data
//   regwrite              frame-buffer write enable
// ----------------------------------------------------------------------------
module fb_write_scheduler #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int H_RES = 160,
    parameter int V_RES = 120
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          px_valid,
    input  logic [7:0]    px_x,
    input  logic [7:0]    px_y,
    input  logic [DW-1:0] px_data,
    output logic          px_ready,
    output logic          px_drop,
    input  logic          fill_start,
    input  logic [7:0]    fill_x0,
    input  logic [7:0]    fill_x1,
    input  logic [7:0]    fill_y0,
    input  logic [7:0]    fill_y1,
    input  logic [DW-1:0] fill_color,
    output logic          fill_busy,
    output logic          fill_done,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite
);

    localparam logic [7:0] X_MAX = 8'(H_RES - 1);
    localparam logic [7:0] Y_MAX = 8'(V_RES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [7:0]    r_x0;
    logic [7:0]    r_x1;
    logic [7:0]    r_y1;
    logic [7:0]    r_cx;
    logic [7:0]    r_cy;
    logic [DW-1:0] r_color;
    logic          r_last_px;   // previous cycle was a contended grant won by the pixel source

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_we;
    logic          r_drop;
    logic          r_busy;
    logic          r_done;

    logic          w_fill_req;
    logic          w_px_grant;
    logic          w_fill_grant;
    logic          w_px_in_range;
    logic [AW-1:0] w_px_addr;
    logic [AW-1:0] w_fill_addr;
    logic [7:0]    w_start_x1;
    logic [7:0]    w_start_y1;
    logic          w_empty;
    logic          w_x_last;
    logic          w_y_last;

    assign w_fill_req = (r_state == FILL);

    // Pixel wins unless it won the previous contended cycle. r_last_px is
    // only set by contended grants, so every new contention starts with the pixel.
    assign w_px_grant   = px_valid && !reset && (!w_fill_req || !r_last_px);
    assign w_fill_grant = w_fill_req && !w_px_grant && !reset;
    assign px_ready     = w_px_grant;

    assign w_px_in_range = (32'(px_x) < H_RES) && (32'(px_y) < V_RES);

    // Arithmetic at AW bits gives the required truncation for free.
    assign w_px_addr   = AW'(px_y) * AW'(H_RES) + AW'(px_x);
    assign w_fill_addr = AW'(r_cy) * AW'(H_RES) + AW'(r_cx);

    assign w_start_x1 = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
    assign w_start_y1 = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
    assign w_empty    = (fill_x0 > w_start_x1) || (fill_y0 > w_start_y1);

    assign w_x_last = (r_cx == r_x1);
    assign w_y_last = (r_cy == r_y1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_x0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_cx      <= '0;
            r_cy      <= '0;
            r_color   <= '0;
            r_last_px <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= 1'b0;
            r_drop    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_last_px <= w_px_grant && w_fill_req;
            r_we      <= 1'b0;
            r_drop    <= 1'b0;
            // fill_done follows the single DONE cycle.
            r_done    <= (r_state == DONE);

            // Write port: at most one grant per cycle.
            if (w_px_grant) begin
                r_addr <= w_px_addr;
                r_data <= px_data;
                r_we   <= w_px_in_range;
                r_drop <= !w_px_in_range;
            end else if (w_fill_grant) begin
                r_addr <= w_fill_addr;
                r_data <= r_color;
                r_we   <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (fill_start) begin
                        r_x0    <= fill_x0;
                        r_x1    <= w_start_x1;
                        r_y1    <= w_start_y1;
                        r_cx    <= fill_x0;
                        r_cy    <= fill_y0;
                        r_color <= fill_color;
                        r_busy  <= 1'b1;
                        r_state <= w_empty ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (w_fill_grant) begin
                        if (w_x_last) begin
                            r_cx <= r_x0;
                            if (w_y_last) begin
                                r_state <= DONE;
                            end else begin
                                r_cy <= r_cy + 8'd1;
                            end
                        end else begin
                            r_cx <= r_cx + 8'd1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_in   = r_addr;
    assign data_in   = r_data;
    assign regwrite  = r_we;
    assign px_drop   = r_drop;
    assign fill_busy = r_busy;
    assign fill_done = r_done;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fb_write_scheduler
//
// Directed bench for fb_write_scheduler (default parameters 160x120, AW=15,
// DW=12). Inputs change 1 time unit after a rising edge. Registered outputs
// are sampled at the same point, so they show the result of that edge.
// ----------------------------------------------------------------------------
module tb_fb_write_scheduler;

    logic        clk;
    logic        reset;
    logic        px_valid;
    logic [7:0]  px_x;
    logic [7:0]  px_y;
    logic [11:0] px_data;
    logic        px_ready;
    logic        px_drop;
    logic        fill_start;
    logic [7:0]  fill_x0;
    logic [7:0]  fill_x1;
    logic [7:0]  fill_y0;
    logic [7:0]  fill_y1;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic [14:0] addr_in;
    logic [11:0] data_in;
    logic        regwrite;

    int n_cmp;
    int n_bad;

    fb_write_scheduler #(
        .AW(15), .DW(12), .H_RES(160), .V_RES(120)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .px_valid   (px_valid),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_data    (px_data),
        .px_ready   (px_ready),
        .px_drop    (px_drop),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_x1    (fill_x1),
        .fill_y0    (fill_y0),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("[tb] %s: got=%0d ok", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_fill(input logic [7:0] x0, input logic [7:0] x1,
                              input logic [7:0] y0, input logic [7:0] y1,
                              input logic [11:0] col);
        fill_x0    = x0;
        fill_x1    = x1;
        fill_y0    = y0;
        fill_y1    = y1;
        fill_color = col;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        fill_x0    = 8'd0;
        fill_x1    = 8'd0;
        fill_y0    = 8'd0;
        fill_y1    = 8'd0;
        fill_color = 12'd0;
    endtask

    initial begin
        int wr_cnt;
        int last_addr;
        int budget;
        logic [14:0] fill_exp [4];
        n_cmp = 0;
        n_bad = 0;

        reset = 1'b1;
        px_valid = 1'b1;
        px_x = 8'd3;
        px_y = 8'd2;
        px_data = 12'hABC;
        fill_start = 1'b0;
        fill_x0 = 8'd0;
        fill_x1 = 8'd0;
        fill_y0 = 8'd0;
        fill_y1 = 8'd0;
        fill_color = 12'd0;

        // Reset state; px_ready held low while reset is high.
        tick();
        tick();
        check_val("rst_ready", 32'(px_ready), 0);
        check_val("rst_regwrite", 32'(regwrite), 0);
        check_val("rst_addr", 32'(addr_in), 0);
        check_val("rst_data", 32'(data_in), 0);
        check_val("rst_drop", 32'(px_drop), 0);
        check_val("rst_busy", 32'(fill_busy), 0);
        check_val("rst_done", 32'(fill_done), 0);

        // Single pixel (3,2) -> address 2*160+3 = 323.
        reset = 1'b0;
        px_data = 12'hF00;
        #1;
        check_val("px_ready", 32'(px_ready), 1);
        tick();
        px_valid = 1'b0;
        check_val("px_regwrite", 32'(regwrite), 1);
        check_val("px_addr", 32'(addr_in), 323);
        check_val("px_data", 32'(data_in), 32'h0F00);
        check_val("px_nodrop", 32'(px_drop), 0);
        tick();
        check_val("px_we_1cyc", 32'(regwrite), 0);

        // Last in-range pixel (159,119) -> 19199.
        px_valid = 1'b1;
        px_x = 8'd159;
        px_y = 8'd119;
        px_data = 12'h123;
        tick();
        px_valid = 1'b0;
        check_val("edge_we", 32'(regwrite), 1);
        check_val("edge_addr", 32'(addr_in), 19199);

        // Off-frame column 200: accepted, dropped.
        px_valid = 1'b1;
        px_x = 8'd200;
        px_y = 8'd0;
        #1;
        check_val("oob_x_ready", 32'(px_ready), 1);
        tick();
        px_valid = 1'b0;
        check_val("oob_x_drop", 32'(px_drop), 1);
        check_val("oob_x_we", 32'(regwrite), 0);

        // Off-frame row 120 (first invalid row).
        px_valid = 1'b1;
        px_x = 8'd0;
        px_y = 8'd120;
        tick();
        px_valid = 1'b0;
        check_val("oob_y_drop", 32'(px_drop), 1);
        check_val("oob_y_we", 32'(regwrite), 0);
        tick();
        check_val("drop_1cyc", 32'(px_drop), 0);

        // Fill (1,1)-(2,2): 161,162,321,322 on consecutive cycles.
        fill_exp[0] = 15'd161;
        fill_exp[1] = 15'd162;
        fill_exp[2] = 15'd321;
        fill_exp[3] = 15'd322;
        start_fill(8'd1, 8'd2, 8'd1, 8'd2, 12'h0F0);
        check_val("f1_busy", 32'(fill_busy), 1);
        check_val("f1_we0", 32'(regwrite), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("f1_we%0d", i), 32'(regwrite), 1);
            check_val($sformatf("f1_addr%0d", i), 32'(addr_in), 32'(fill_exp[i]));
            check_val($sformatf("f1_data%0d", i), 32'(data_in), 32'h0F0);
        end
        check_val("f1_done_early", 32'(fill_done), 0);
        tick();
        check_val("f1_done", 32'(fill_done), 1);
        check_val("f1_busy_low", 32'(fill_busy), 0);
        check_val("f1_we_end", 32'(regwrite), 0);
        tick();
        check_val("f1_done_1cyc", 32'(fill_done), 0);

        // Empty fill (x0=5 > x1=2): no writes, done 2 cycles after start.
        start_fill(8'd5, 8'd2, 8'd0, 8'd0, 12'hFFF);
        check_val("emp_we0", 32'(regwrite), 0);
        check_val("emp_done0", 32'(fill_done), 0);
        check_val("emp_busy", 32'(fill_busy), 1);
        tick();
        check_val("emp_we1", 32'(regwrite), 0);
        check_val("emp_done", 32'(fill_done), 1);
        tick();
        check_val("emp_done_1cyc", 32'(fill_done), 0);

        // Fill (0,0)-(3,0) with px_valid held high at (10,0) -> addr 10.
        px_valid = 1'b1;
        px_x = 8'd10;
        px_y = 8'd0;
        px_data = 12'h0AB;
        #1;
        check_val("alt_ready_start", 32'(px_ready), 1);
        start_fill(8'd0, 8'd3, 8'd0, 8'd0, 12'h00F);
        check_val("alt_first_addr", 32'(addr_in), 10);
        for (int i = 0; i < 8; i++) begin
            logic pix_turn;
            pix_turn = ((i % 2) == 0);
            check_val($sformatf("alt_ready%0d", i), 32'(px_ready), 32'(pix_turn));
            tick();
            check_val($sformatf("alt_we%0d", i), 32'(regwrite), 1);
            check_val($sformatf("alt_addr%0d", i), 32'(addr_in), pix_turn ? 10 : i / 2);
            check_val($sformatf("alt_data%0d", i), 32'(data_in), pix_turn ? 32'h0AB : 32'h00F);
        end
        // DONE cycle: pixel is the only requester.
        check_val("alt_ready_done", 32'(px_ready), 1);
        tick();
        px_valid = 1'b0;
        check_val("alt_fill_done", 32'(fill_done), 1);
        check_val("alt_px_we", 32'(regwrite), 1);
        check_val("alt_px_addr", 32'(addr_in), 10);
        tick();

        // Full-frame fill with oversized corners (clamped) and a stray
        // fill_start mid-fill that must be ignored.
        start_fill(8'd0, 8'd255, 8'd0, 8'd255, 12'h555);
        wr_cnt = 0;
        last_addr = -1;
        budget = 0;
        while (fill_done !== 1'b1 && budget < 25000) begin
            if (budget == 100) begin
                fill_x0 = 8'd50;
                fill_x1 = 8'd60;
                fill_y0 = 8'd50;
                fill_y1 = 8'd60;
                fill_start = 1'b1;
            end else begin
                fill_start = 1'b0;
            end
            tick();
            if (regwrite === 1'b1) begin
                wr_cnt++;
                last_addr = int'(addr_in);
            end
            budget++;
        end
        fill_start = 1'b0;
        check_val("full_done_seen", 32'(fill_done), 1);
        check_val("full_count", 32'(wr_cnt), 19200);
        check_val("full_last_addr", 32'(last_addr), 19199);
        tick();

        // Reset after 10 writes of a full-frame fill.
        start_fill(8'd0, 8'd159, 8'd0, 8'd119, 12'h321);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val($sformatf("rf_addr%0d", i), 32'(addr_in), i);
        end
        reset = 1'b1;
        px_valid = 1'b1;
        px_x = 8'd1;
        px_y = 8'd1;
        #1;
        check_val("rf_ready_in_rst", 32'(px_ready), 0);
        tick();
        reset = 1'b0;
        px_valid = 1'b0;
        check_val("rf_we", 32'(regwrite), 0);
        check_val("rf_busy", 32'(fill_busy), 0);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (regwrite === 1'b1 || fill_done === 1'b1 || fill_busy === 1'b1) wr_cnt++;
        end
        check_val("rf_no_activity", 32'(wr_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 SHALL have parameter AW, default 15, frame-buffer address width.
REQ-002 SHALL have parameter DW, default 12, pixel data width.
REQ-003 SHALL have parameter H_RES, default 160, frame width in pixels.
REQ-004 SHALL have parameter V_RES, default 120, frame height in pixels.
REQ-005 SHALL have port clk  input  1  single clock for all logic; the frame-buffer write clock connects to clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port px_valid  input  1  single-pixel write request.
REQ-008 SHALL have port px_x  input  8  pixel column.
REQ-009 SHALL have port px_y  input  8  pixel row.
REQ-010 SHALL have port px_data  input  DW  pixel colour.
REQ-011 SHALL have port px_ready  output  1  pixel request accepted this cycle.
REQ-012 SHALL have port px_drop  output  1  one-cycle pulse: accepted pixel was out of range and discarded.
REQ-013 SHALL have port fill_start  input  1  start rectangle fill.
REQ-014 SHALL have ports fill_x0, fill_x1, fill_y0, fill_y1  input  8 each  inclusive rectangle corners.
REQ-015 SHALL have port fill_color  input  DW  fill colour.
REQ-016 SHALL have port fill_busy  output  1  fill in progress.
REQ-017 SHALL have port fill_done  output  1  one-cycle pulse at fill completion.
REQ-018 SHALL have port addr_in  output  AW  to frame-buffer write address.
REQ-019 SHALL have port data_in  output  DW  to frame-buffer write data.
REQ-020 SHALL have port regwrite  output  1  to frame-buffer write enable.

Function
REQ-021 SHALL compute addr_in = y*H_RES + x, truncated to AW bits.
REQ-022 SHALL register addr_in, data_in and regwrite: a write granted in cycle N appears on these outputs in cycle N+1, for exactly one cycle.
REQ-023 SHALL implement states IDLE, FILL, DONE.
REQ-024 SHALL, in IDLE on fill_start=1, latch corners and colour, clamp x1 to min(fill_x1,H_RES-1) and y1 to min(fill_y1,V_RES-1), set cursor to (x0,y0), and enter FILL.
REQ-025 SHALL treat a fill with x0>clamped x1 or y0>clamped y1 as empty: no writes, go directly to DONE.
REQ-026 SHALL, in FILL, advance the cursor only on cycles the fill is granted: x increments; at x=x1 x returns to x0 and y increments; the write at (x1,y1) enters DONE.
REQ-027 SHALL, in DONE, assert fill_done for one cycle and return to IDLE.
REQ-028 SHALL assert fill_busy in FILL and DONE, deasserted in IDLE.
REQ-029 SHALL ignore fill_start outside IDLE; corner inputs are sampled only at start.
REQ-030 SHALL arbitrate one write per cycle: if only one source requests it is granted; if px_valid=1 during FILL, grants alternate, pixel first, then fill, then pixel.
REQ-031 SHALL assert px_ready combinationally in the cycle the pixel source is granted.
REQ-032 SHALL, for an accepted pixel with px_x>=H_RES or px_y>=V_RES, suppress regwrite and pulse px_drop in cycle N+1.
REQ-033 SHALL permit px_ready=1 and fill_done=1 in the same cycle.
REQ-034 SHALL make a full-frame fill (0,0)-(H_RES-1,V_RES-1) produce exactly H_RES*V_RES writes.

Reset
REQ-035 SHALL, on reset=1 at a clk edge, enter IDLE and clear addr_in, data_in, regwrite, px_drop, fill_busy and fill_done to 0; px_ready is 0 while reset=1.
REQ-036 SHALL abort an in-progress fill on reset, with no further writes and no fill_done.

Verification
REQ-037 SHALL cover: px_valid, x=3, y=2, data=12'hF00 in IDLE -> px_ready=1; next cycle regwrite=1, addr_in=323, data_in=12'hF00.
REQ-038 SHALL cover: fill (1,1)-(2,2), colour 12'h0F0 -> writes to addresses 161,162,321,322 on consecutive cycles, then fill_done pulse, fill_busy low after.
REQ-039 SHALL cover: fill (0,0)-(3,0) with px_valid held high -> writes alternate pixel/fill, 4 fill writes over 8 cycles, pixel writes each get px_ready.
REQ-040 SHALL cover: fill x0=5, x1=2 -> no regwrite, fill_done exactly 2 cycles after start.
REQ-041 SHALL cover: px_x=200 -> px_ready=1, px_drop=1 next cycle, regwrite=0.
REQ-042 SHALL cover: reset during fill (0,0)-(159,119) after 10 writes -> regwrite=0 and fill_busy=0 from the following cycle, no fill_done.
